// File: rtl/blake_pkg.sv
// Shared constants for the BLAKE round sequencer: SIGMA permutation table,
// round count and sequencer state encoding.
package blake_pkg;

  localparam int unsigned BLAKE512_ROUNDS = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_FIN  = S_FIN
  } seq_state_e;

  // Each row packs sigma[r][0..15] as 4-bit nibbles, sigma[r][i] at bits [4i+3:4i].
  localparam logic [63:0] SIGMA [10] = '{
    64'hFEDC_BA98_7654_3210,
    64'h357B_20C1_6DF9_84AE,
    64'h4917_63EA_DF25_0C8B,
    64'h8F04_A562_EBCD_1397,
    64'hD386_CB1E_FA42_7509,
    64'h91EF_57D4_38B0_A6C2,
    64'hB829_3670_A4DE_F15C,
    64'hA268_4F05_931C_E7BD,
    64'h5A41_7D2C_803B_9EF6,
    64'h0DC3_E9BF_5167_482A
  };

  // Rows 10..15 cannot occur; they fall back to row 0 so the decode stays total.
  function automatic logic [63:0] sigma_row_get(input logic [3:0] row);
    logic [63:0] val;
    val = SIGMA[0];
    if (row < 4'd10) val = SIGMA[row];
    return val;
  endfunction

endpackage

// File: rtl/blake_sigma_decode.sv
// Combinational map from (sigma_row, step) to the eight message-word indices
// used by the four G functions active in that half-round.
module blake_sigma_decode
  import blake_pkg::*;
(
  input  logic [3:0]  i_sigma_row,
  input  logic        i_step,
  output logic [31:0] o_msg_idx
);

  logic [63:0] w_row;
  logic [31:0] w_half;

  // Pick the column or diagonal half of the row, then place sigma[2j] in the
  // upper nibble and sigma[2j+1] in the lower nibble of each G byte.
  always_comb begin
    w_row     = sigma_row_get(i_sigma_row);
    w_half    = i_step ? w_row[63:32] : w_row[31:0];
    o_msg_idx = '0;
    for (int k = 0; k < 4; k++) begin
      o_msg_idx[8*k+4 +: 4] = w_half[8*k +: 4];
      o_msg_idx[8*k +: 4]   = w_half[8*k+4 +: 4];
    end
  end

endmodule

// File: rtl/blake_round_sequencer.sv
// BLAKE round sequencer: responds to the core controller's init_round /
// round_ing handshake, walks round/step/sigma_row and reports count_done and
// a finalisation pulse. Optional protocol checker enabled by the macro
// BLAKE_SEQ_PROTO_CHK_EN (adds o_proto_err).
module blake_round_sequencer
  import blake_pkg::*;
#(
  parameter int unsigned NROUNDS = BLAKE512_ROUNDS,
  parameter int unsigned RIDX_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_init_round,
  input  logic              i_round_ing,
  output logic              o_count_done,
  output logic [RIDX_W-1:0] o_round_idx,
  output logic              o_step,
  output logic [3:0]        o_sigma_row,
  output logic [31:0]       o_msg_idx,
  output logic              o_fin_pulse
`ifdef BLAKE_SEQ_PROTO_CHK_EN
  ,
  output logic              o_proto_err
`endif
);

  seq_state_e        r_state;
  logic [RIDX_W-1:0] r_round_idx;
  logic              r_step;
  logic [3:0]        r_sigma_row;
  logic              r_fin_pulse;
  logic              w_count_done;

  // Last step of the last round, while the controller is actively rounding.
  always_comb begin
    w_count_done = (r_state == ST_RUN) && i_round_ing &&
                   (r_round_idx == RIDX_W'(NROUNDS - 1)) && r_step;
  end

  // Sequencer FSM with round/step/sigma counters; init_round restarts from any state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_round_idx <= '0;
      r_step      <= 1'b0;
      r_sigma_row <= 4'd0;
      r_fin_pulse <= 1'b0;
    end else begin
      r_fin_pulse <= 1'b0;
      if (i_init_round) begin
        r_state     <= ST_RUN;
        r_round_idx <= '0;
        r_step      <= 1'b0;
        r_sigma_row <= 4'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_RUN: begin
            if (i_round_ing) begin
              if (w_count_done) begin
                // Counters stay parked at the terminal value until next init_round.
                r_state     <= ST_FIN;
                r_fin_pulse <= 1'b1;
              end else begin
                r_step <= ~r_step;
                if (r_step) begin
                  r_round_idx <= r_round_idx + RIDX_W'(1);
                  r_sigma_row <= (r_sigma_row == 4'd9) ? 4'd0 : r_sigma_row + 4'd1;
                end
              end
            end
          end
          ST_FIN: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef BLAKE_SEQ_PROTO_CHK_EN
  logic r_proto_err;

  // Sticky flag for handshake violations; only reset clears it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_proto_err <= 1'b0;
    end else if ((r_state == ST_IDLE && i_round_ing && !i_init_round) ||
                 (r_state == ST_RUN && i_init_round) ||
                 (r_state == ST_FIN && i_round_ing)) begin
      r_proto_err <= 1'b1;
    end
  end

  assign o_proto_err = r_proto_err;
`endif

  blake_sigma_decode u_sigma_decode (
    .i_sigma_row (r_sigma_row),
    .i_step      (r_step),
    .o_msg_idx   (o_msg_idx)
  );

  assign o_count_done = w_count_done;
  assign o_round_idx  = r_round_idx;
  assign o_step       = r_step;
  assign o_sigma_row  = r_sigma_row;
  assign o_fin_pulse  = r_fin_pulse;

endmodule

// File: tb/tb_blake_round_sequencer.sv
// Directed bench for blake_round_sequencer: full run, stall, restart, mid-run
// reset and (when BLAKE_SEQ_PROTO_CHK_EN is defined) the protocol checker.
module tb_blake_round_sequencer;

  logic        clk;
  logic        rst;
  logic        init_round;
  logic        round_ing;
  logic        count_done;
  logic [3:0]  round_idx;
  logic        step;
  logic [3:0]  sigma_row;
  logic [31:0] msg_idx;
  logic        fin_pulse;
`ifdef BLAKE_SEQ_PROTO_CHK_EN
  logic        proto_err;
`endif

  int n_chk;
  int n_fail;

  blake_round_sequencer #(
    .NROUNDS (16),
    .RIDX_W  (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_init_round (init_round),
    .i_round_ing  (round_ing),
    .o_count_done (count_done),
    .o_round_idx  (round_idx),
    .o_step       (step),
    .o_sigma_row  (sigma_row),
    .o_msg_idx    (msg_idx),
    .o_fin_pulse  (fin_pulse)
`ifdef BLAKE_SEQ_PROTO_CHK_EN
    ,
    .o_proto_err  (proto_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check counters against an expected linear step position (2*round + step).
  task automatic chk_pos(input string tag, input int pos);
    chk({tag, "_round"}, 32'(round_idx), 32'(pos / 2));
    chk({tag, "_step"}, 32'(step), 32'(pos % 2));
    chk({tag, "_sigma"}, 32'(sigma_row), 32'((pos / 2) % 10));
  endtask

  initial begin
    int pos;
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    init_round = 1'b0;
    round_ing  = 1'b0;
    #1;
    // Reset values
    chk("rst_round", 32'(round_idx), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_sigma", 32'(sigma_row), 32'd0);
    chk("rst_cd", 32'(count_done), 32'd0);
    chk("rst_fin", 32'(fin_pulse), 32'd0);
    chk("rst_msg", msg_idx, 32'h6745_2301);
`ifdef BLAKE_SEQ_PROTO_CHK_EN
    chk("rst_perr", 32'(proto_err), 32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;

    // A: full run, init_round with round_ing also high at cycle 0
    tick();
    init_round = 1'b1;
    round_ing  = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      tick();
      init_round = 1'b0;
      round_ing  = (c <= 32);
      #1;
      pos = (c <= 32) ? c - 1 : 31;
      chk_pos("A", pos);
      chk("A_cd", 32'(count_done), 32'(c == 32));
      chk("A_fin", 32'(fin_pulse), 32'(c == 33));
      if (c == 4) chk("A_r1_diag_msg", msg_idx, 32'h53B7_021C);
      if (c == 21) begin
        chk("A_r10_sigma", 32'(sigma_row), 32'd0);
        chk("A_r10_msg", msg_idx, 32'h6745_2301);
      end
    end

    // B: stall at round 5 step 1 for 3 cycles
    init_round = 1'b1;
    round_ing  = 1'b1;
    for (int c = 1; c <= 37; c++) begin
      tick();
      init_round = 1'b0;
      round_ing  = !(c >= 12 && c <= 14) && (c <= 35);
      #1;
      if (c <= 12) pos = c - 1;
      else if (c <= 15) pos = 11;
      else pos = (c - 4 > 31) ? 31 : c - 4;
      chk_pos("B", pos);
      chk("B_cd", 32'(count_done), 32'(c == 35));
      chk("B_fin", 32'(fin_pulse), 32'(c == 36));
    end

    // C: restart with init_round at round 7
    init_round = 1'b1;
    round_ing  = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      init_round = (c == 15);
      #1;
      chk_pos("C1", c - 1);
      chk("C1_fin", 32'(fin_pulse), 32'd0);
    end
    chk("C1_r7", 32'(round_idx), 32'd7);
    for (int d = 1; d <= 34; d++) begin
      tick();
      init_round = 1'b0;
      round_ing  = (d <= 32);
      #1;
      chk_pos("C2", (d <= 32) ? d - 1 : 31);
      chk("C2_cd", 32'(count_done), 32'(d == 32));
      chk("C2_fin", 32'(fin_pulse), 32'(d == 33));
    end

    // D: reset at round 12
    init_round = 1'b1;
    round_ing  = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      init_round = 1'b0;
    end
    chk("D_r12", 32'(round_idx), 32'd12);
    rst = 1'b1;
    #1;
    chk("D_rst_round", 32'(round_idx), 32'd0);
    chk("D_rst_step", 32'(step), 32'd0);
    chk("D_rst_sigma", 32'(sigma_row), 32'd0);
    chk("D_rst_cd", 32'(count_done), 32'd0);
    chk("D_rst_fin", 32'(fin_pulse), 32'd0);
    chk("D_rst_msg", msg_idx, 32'h6745_2301);
`ifdef BLAKE_SEQ_PROTO_CHK_EN
    chk("D_rst_perr", 32'(proto_err), 32'd0);
`endif
    tick();
    rst = 1'b0;
    // round_ing in idle is ignored
    for (int c = 1; c <= 3; c++) begin
      tick();
      #1;
      chk_pos("D_idle", 0);
      chk("D_idle_cd", 32'(count_done), 32'd0);
      chk("D_idle_fin", 32'(fin_pulse), 32'd0);
    end

`ifdef BLAKE_SEQ_PROTO_CHK_EN
    // round_ing held in idle above must have set the sticky error
    chk("E_perr_set", 32'(proto_err), 32'd1);
    round_ing = 1'b0;
    tick();
    tick();
    chk("E_perr_sticky", 32'(proto_err), 32'd1);
    rst = 1'b1;
    #1;
    chk("E_perr_clr", 32'(proto_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("E_perr_quiet", 32'(proto_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
